// File: rtl/dvi_pkg.sv
// Shared types and 640x480 defaults for the DVI link sequencer.
// Holds state codes, per-state control bundle and counter sizing.
package dvi_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_BLANK     = 3'd1,
        ST_IDLE      = 3'd2,
        ST_ACTIVE    = 3'd3,
        ST_DRAIN     = 3'd4
    } state_e;

    typedef struct packed {
        logic tg_rstn;
        logic ser_en;
        logic video_en;
    } link_ctl_t;

    localparam int unsigned H_TOTAL = 800;
    localparam int unsigned V_TOTAL = 525;

    localparam int unsigned DEF_LOCK_CYCLES  = 1024;
    localparam int unsigned DEF_BLANK_FRAMES = 2;
    // One full 800x525 frame rounded up to a power of two.
    localparam int unsigned DEF_VS_TIMEOUT   =
        2 ** $clog2(H_TOTAL * V_TOTAL);

    function automatic int unsigned cnt_w(input int unsigned term);
        return (term > 1) ? $clog2(term) : 1;
    endfunction

    function automatic link_ctl_t state_ctl(input state_e s);
        link_ctl_t c;
        case (s)
            ST_WAIT_LOCK: c = '{1'b0, 1'b0, 1'b0};
            ST_ACTIVE,
            ST_DRAIN:     c = '{1'b1, 1'b1, 1'b1};
            default:      c = '{1'b1, 1'b1, 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for single- or multi-bit level signals.
// Asynchronous active-low reset to a configurable value.
module sync_2ff #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/dvi_link_sequencer.sv
// DVI transmit start-up/run-time sequencer in the pixel-clock domain.
// Releases TG/serializer after PLL lock, blanks, gates video at vsync.
module dvi_link_sequencer
    import dvi_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES   = DEF_LOCK_CYCLES,
    parameter int unsigned BLANK_FRAMES  = DEF_BLANK_FRAMES,
    parameter int unsigned VS_TIMEOUT    = DEF_VS_TIMEOUT,
    parameter bit          VS_ACTIVE_LOW = 1'b1,
    parameter int unsigned FRAME_CNT_W   = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_pll_locked,
    input  logic                   i_enable,
    input  logic                   i_vs,
    output logic                   o_tg_rstn,
    output logic                   o_ser_en,
    output logic                   o_video_en,
    output logic [2:0]             o_state,
    output logic [FRAME_CNT_W-1:0] o_frame_cnt,
    output logic                   o_err
);

    localparam int unsigned LCW = cnt_w(LOCK_CYCLES);
    localparam int unsigned BCW = cnt_w(BLANK_FRAMES);
    localparam int unsigned WCW = cnt_w(VS_TIMEOUT);

    localparam logic [LCW-1:0] LOCK_LAST  = LCW'(LOCK_CYCLES - 1);
    localparam logic [BCW-1:0] BLANK_LAST = BCW'(BLANK_FRAMES - 1);
    localparam logic [WCW-1:0] WD_LAST    = WCW'(VS_TIMEOUT - 1);

    logic lock_s;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_d    (i_pll_locked),
        .o_q    (lock_s)
    );

    logic vs_q;
    logic vs_act;
    logic vs_prev_act;
    logic vs_edge;

    assign vs_act      = VS_ACTIVE_LOW ? ~i_vs : i_vs;
    assign vs_prev_act = VS_ACTIVE_LOW ? ~vs_q : vs_q;
    assign vs_edge     = vs_act & ~vs_prev_act;

    state_e                 state_q, state_d;
    logic [LCW-1:0]         lock_cnt_q, lock_cnt_d;
    logic [BCW-1:0]         blank_cnt_q, blank_cnt_d;
    logic [WCW-1:0]         wd_q, wd_d;
    logic [FRAME_CNT_W-1:0] frame_q, frame_d;
    logic                   err_q, err_d;
    link_ctl_t              ctl_q;
    logic                   wd_hit;

    assign wd_hit = (wd_q == WD_LAST) && !vs_edge;

    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        blank_cnt_d = blank_cnt_q;
        wd_d        = wd_q;
        frame_d     = frame_q;
        err_d       = err_q;

        if (state_q == ST_WAIT_LOCK) begin
            blank_cnt_d = '0;
            wd_d        = '0;
            frame_d     = '0;
            if (!lock_s) begin
                lock_cnt_d = '0;
            end else if (lock_cnt_q == LOCK_LAST) begin
                lock_cnt_d = '0;
                state_d    = ST_BLANK;
            end else begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end else if (!lock_s || wd_hit) begin
            // Lock loss outranks the watchdog, so err only on a clean timeout.
            state_d     = ST_WAIT_LOCK;
            lock_cnt_d  = '0;
            blank_cnt_d = '0;
            wd_d        = '0;
            frame_d     = '0;
            err_d       = err_q | lock_s;
        end else begin
            wd_d = vs_edge ? '0 : wd_q + 1'b1;
            if (vs_edge) begin
                frame_d = frame_q + 1'b1;
            end
            case (state_q)
                ST_BLANK: begin
                    if (vs_edge) begin
                        if (blank_cnt_q == BLANK_LAST) begin
                            blank_cnt_d = '0;
                            state_d     = i_enable ? ST_ACTIVE : ST_IDLE;
                        end else begin
                            blank_cnt_d = blank_cnt_q + 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (vs_edge && i_enable) begin
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (!i_enable) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (i_enable) begin
                        state_d = ST_ACTIVE;
                    end else if (vs_edge) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= ST_WAIT_LOCK;
            lock_cnt_q  <= '0;
            blank_cnt_q <= '0;
            wd_q        <= '0;
            frame_q     <= '0;
            err_q       <= 1'b0;
            vs_q        <= 1'b0;
            ctl_q       <= '0;
        end else begin
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            wd_q        <= wd_d;
            frame_q     <= frame_d;
            err_q       <= err_d;
            vs_q        <= i_vs;
            ctl_q       <= state_ctl(state_d);
        end
    end

    assign o_state     = state_q;
    assign o_tg_rstn   = ctl_q.tg_rstn;
    assign o_ser_en    = ctl_q.ser_en;
    assign o_video_en  = ctl_q.video_en;
    assign o_frame_cnt = frame_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_dvi_link_sequencer.sv
// Directed bench: two sequencers (low- and high-active vsync) driven
// in lockstep and checked against hand-computed edge-exact values.
module tb_dvi_link_sequencer;

    logic clk;
    logic rst_n;
    logic lock;
    logic en;
    logic vs_act;

    logic       a_tg, a_ser, a_vid, a_err;
    logic [2:0] a_st;
    logic [3:0] a_fc;
    logic       b_tg, b_ser, b_vid, b_err;
    logic [2:0] b_st;
    logic [3:0] b_fc;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    int e0;

    dvi_link_sequencer #(
        .LOCK_CYCLES   (16),
        .BLANK_FRAMES  (2),
        .VS_TIMEOUT    (100),
        .VS_ACTIVE_LOW (1'b1),
        .FRAME_CNT_W   (4)
    ) dut_a (
        .i_clk        (clk),
        .i_rstn       (rst_n),
        .i_pll_locked (lock),
        .i_enable     (en),
        .i_vs         (~vs_act),
        .o_tg_rstn    (a_tg),
        .o_ser_en     (a_ser),
        .o_video_en   (a_vid),
        .o_state      (a_st),
        .o_frame_cnt  (a_fc),
        .o_err        (a_err)
    );

    dvi_link_sequencer #(
        .LOCK_CYCLES   (16),
        .BLANK_FRAMES  (2),
        .VS_TIMEOUT    (100),
        .VS_ACTIVE_LOW (1'b0),
        .FRAME_CNT_W   (4)
    ) dut_b (
        .i_clk        (clk),
        .i_rstn       (rst_n),
        .i_pll_locked (lock),
        .i_enable     (en),
        .i_vs         (vs_act),
        .o_tg_rstn    (b_tg),
        .o_ser_en     (b_ser),
        .o_video_en   (b_vid),
        .o_state      (b_st),
        .o_frame_cnt  (b_fc),
        .o_err        (b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        edge_n <= rst_n ? edge_n + 1 : 0;
    end

    // Packed word: state, tg_rstn, ser_en, video_en, err, frame_cnt.
    function automatic logic [10:0] w(
        input logic [2:0] st, input logic tg, input logic ser,
        input logic vid, input logic err, input logic [3:0] fc);
        return {st, tg, ser, vid, err, fc};
    endfunction

    task automatic chk(input string tag, input logic [10:0] exp);
        logic [10:0] oa;
        logic [10:0] ob;
        oa = {a_st, a_tg, a_ser, a_vid, a_err, a_fc};
        ob = {b_st, b_tg, b_ser, b_vid, b_err, b_fc};
        total++;
        assert (oa === exp) else begin
            bad++;
            $error("FAIL %s/lowvs observed=%h expected=%h", tag, oa, exp);
        end
        total++;
        assert (ob === exp) else begin
            bad++;
            $error("FAIL %s/highvs observed=%h expected=%h", tag, ob, exp);
        end
    endtask

    task automatic to_edge(input int n);
        while (edge_n < n) @(negedge clk);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vpulse();
        vs_act = 1'b1;
        @(negedge clk);
    endtask

    task automatic vgap(input int n);
        cyc(3);
        vs_act = 1'b0;
        cyc(n - 3);
    endtask

    initial begin
        rst_n  = 1'b0;
        lock   = 1'b0;
        en     = 1'b0;
        vs_act = 1'b0;
        cyc(3);
        chk("reset", w(3'd0, 0, 0, 0, 0, 4'd0));

        // power-up, no glitch: BLANK from edge 27
        rst_n = 1'b1;
        to_edge(9);
        lock = 1'b1;
        to_edge(26);
        chk("pre_release", w(3'd0, 0, 0, 0, 0, 4'd0));
        to_edge(27);
        chk("release27", w(3'd1, 1, 1, 0, 0, 4'd0));

        rst_n = 1'b0;
        #1;
        chk("async_reset", w(3'd0, 0, 0, 0, 0, 4'd0));
        lock = 1'b0;
        cyc(3);

        // power-up with a one-cycle lock glitch: release moves to 37
        rst_n = 1'b1;
        to_edge(9);
        lock = 1'b1;
        to_edge(18);
        lock = 1'b0;
        to_edge(19);
        lock = 1'b1;
        to_edge(27);
        chk("glitch27", w(3'd0, 0, 0, 0, 0, 4'd0));
        to_edge(36);
        chk("glitch36", w(3'd0, 0, 0, 0, 0, 4'd0));
        to_edge(37);
        chk("glitch37", w(3'd1, 1, 1, 0, 0, 4'd0));

        // blank frames
        en = 1'b1;
        vpulse();
        chk("blank1", w(3'd1, 1, 1, 0, 0, 4'd1));
        vgap(48);
        vpulse();
        chk("blank2", w(3'd3, 1, 1, 1, 0, 4'd2));

        // drain to idle at next vsync
        vgap(20);
        en = 1'b0;
        cyc(1);
        chk("drain", w(3'd4, 1, 1, 1, 0, 4'd2));
        cyc(27);
        chk("drain_hold", w(3'd4, 1, 1, 1, 0, 4'd2));
        vpulse();
        chk("drain_idle", w(3'd2, 1, 1, 0, 0, 4'd3));
        vgap(48);
        chk("idle_hold", w(3'd2, 1, 1, 0, 0, 4'd3));
        en = 1'b1;
        vpulse();
        chk("idle_act", w(3'd3, 1, 1, 1, 0, 4'd4));

        // re-enable in the vsync-edge cycle: stays active, no gap
        vgap(20);
        en = 1'b0;
        cyc(1);
        chk("drain2", w(3'd4, 1, 1, 1, 0, 4'd4));
        cyc(26);
        en = 1'b1;
        vpulse();
        chk("reenable", w(3'd3, 1, 1, 1, 0, 4'd5));

        // frame counter wrap at 4 bits
        for (int i = 0; i < 11; i++) begin
            vgap(48);
            vpulse();
        end
        chk("wrap16", w(3'd3, 1, 1, 1, 0, 4'd0));
        vgap(48);
        vpulse();
        chk("wrap17", w(3'd3, 1, 1, 1, 0, 4'd1));

        // lock loss in ACTIVE
        vgap(10);
        lock = 1'b0;
        cyc(3);
        chk("lockloss", w(3'd0, 0, 0, 0, 0, 4'd0));

        // relock repeats the sequence
        e0 = edge_n;
        lock = 1'b1;
        to_edge(e0 + 17);
        chk("relock_pre", w(3'd0, 0, 0, 0, 0, 4'd0));
        to_edge(e0 + 18);
        chk("relock", w(3'd1, 1, 1, 0, 0, 4'd0));
        vpulse();
        vgap(48);
        vpulse();
        chk("relock_act", w(3'd3, 1, 1, 1, 0, 4'd2));

        // watchdog: vsync stops
        e0 = edge_n;
        cyc(3);
        vs_act = 1'b0;
        to_edge(e0 + 99);
        chk("wd_pre", w(3'd3, 1, 1, 1, 0, 4'd2));
        to_edge(e0 + 100);
        chk("wd_fire", w(3'd0, 0, 0, 0, 1, 4'd0));
        to_edge(e0 + 115);
        chk("wd_wait", w(3'd0, 0, 0, 0, 1, 4'd0));
        to_edge(e0 + 116);
        chk("wd_relock", w(3'd1, 1, 1, 0, 1, 4'd0));

        rst_n = 1'b0;
        #1;
        chk("err_clear", w(3'd0, 0, 0, 0, 0, 4'd0));
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
